// File: rtl/round_timer_controller_pkg.sv
// Shared types for the round timer: FSM state codes, winner codes and the BCD digit.
// Also hosts the two-digit BCD increment used by the counter and the limit check.
package round_timer_controller_pkg;

   localparam int unsigned PRESC_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   typedef enum logic [1:0] {
      WIN_NONE = 2'b00,
      WIN_RED  = 2'b01,
      WIN_BLUE = 2'b10,
      WIN_TIE  = 2'b11
   } winner_t;

   typedef logic [3:0] bcd_digit_t;

   // Units wrap 9->0 with carry; tens wrap 9->0 so no digit ever exceeds 9.
   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      bcd_digit_t tens;
      bcd_digit_t units;
      tens  = v[7:4];
      units = v[3:0];
      if (units >= 4'd9) begin
         units = 4'd0;
         tens  = (tens >= 4'd9) ? 4'd0 : 4'(tens + 4'd1);
      end else begin
         units = 4'(units + 4'd1);
      end
      return {tens, units};
   endfunction

endpackage

// File: rtl/bcd_pair_counter.sv
// Two-digit packed-BCD up counter with synchronous clear and count enable.
module bcd_pair_counter
   import round_timer_controller_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       i_clr,
   input  logic       i_en,
   output logic [7:0] o_count
);

   bcd_digit_t r_tens;
   bcd_digit_t r_units;
   logic [7:0] w_next;

   assign w_next = bcd_inc({r_tens, r_units});

   always_ff @(posedge clk) begin
      if (!reset_n || i_clr) begin
         r_tens  <= '0;
         r_units <= '0;
      end else if (i_en) begin
         r_tens  <= w_next[7:4];
         r_units <= w_next[3:0];
      end
   end

   assign o_count = {r_tens, r_units};

endmodule

// File: rtl/round_timer_controller.sv
// Two-player round timer: counts seconds in BCD, ends the round on the first
// fresh button press or when the elapsed time reaches ROUND_LIMIT.
module round_timer_controller
   import round_timer_controller_pkg::*;
#(
   parameter int unsigned TICKS_PER_SEC = 1000,
   parameter logic [7:0]  ROUND_LIMIT   = 8'h30
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   input  logic       red_button,
   input  logic       blue_button,
   output logic [7:0] count,
   output logic [1:0] state,
   output logic [1:0] winner,
   output logic       timeout,
   output logic       tick
);

   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);

   state_t             r_state,   w_state_nxt;
   winner_t            r_winner,  w_winner_nxt;
   logic               r_timeout, w_timeout_nxt;
   logic               r_tick,    w_tick_nxt;
   logic [PRESC_W-1:0] r_presc,   w_presc_nxt;
   logic               r_start_d, r_red_d, r_blue_d;
   logic               w_start_edge, w_red_edge, w_blue_edge;
   logic               w_term;
   logic               w_cnt_clr, w_cnt_en;
   logic [7:0]         w_count;

   assign w_start_edge = start       & ~r_start_d;
   assign w_red_edge   = red_button  & ~r_red_d;
   assign w_blue_edge  = blue_button & ~r_blue_d;
   assign w_term       = (r_presc == PRESC_LAST);

   bcd_pair_counter u_bcd_pair_counter (
      .clk     (clk),
      .reset_n (reset_n),
      .i_clr   (w_cnt_clr),
      .i_en    (w_cnt_en),
      .o_count (w_count)
   );

   // Next-state and next-output logic.
   always_comb begin
      w_state_nxt   = r_state;
      w_winner_nxt  = r_winner;
      w_timeout_nxt = r_timeout;
      w_tick_nxt    = 1'b0;
      w_presc_nxt   = r_presc;
      w_cnt_clr     = 1'b0;
      w_cnt_en      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_presc_nxt   = '0;
            w_winner_nxt  = WIN_NONE;
            w_timeout_nxt = 1'b0;
            if (w_start_edge) w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            w_tick_nxt  = w_term;
            w_presc_nxt = w_term ? '0 : r_presc + PRESC_W'(1);
            // A press outranks a same-cycle tick: the count is frozen as-is.
            if (w_red_edge || w_blue_edge) begin
               w_state_nxt  = ST_DONE;
               w_winner_nxt = winner_t'({w_blue_edge, w_red_edge});
            end else if (w_term) begin
               w_cnt_en = 1'b1;
               if (bcd_inc(w_count) == ROUND_LIMIT) begin
                  w_state_nxt   = ST_DONE;
                  w_timeout_nxt = 1'b1;
               end
            end
         end
         ST_DONE: begin
            if (w_start_edge) begin
               w_state_nxt   = ST_IDLE;
               w_winner_nxt  = WIN_NONE;
               w_timeout_nxt = 1'b0;
               w_presc_nxt   = '0;
               w_cnt_clr     = 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Reset loads current input levels so a level held through reset is not an edge.
   always_ff @(posedge clk) begin
      r_start_d <= start;
      r_red_d   <= red_button;
      r_blue_d  <= blue_button;
      if (!reset_n) begin
         r_state   <= ST_IDLE;
         r_winner  <= WIN_NONE;
         r_timeout <= 1'b0;
         r_tick    <= 1'b0;
         r_presc   <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_winner  <= w_winner_nxt;
         r_timeout <= w_timeout_nxt;
         r_tick    <= w_tick_nxt;
         r_presc   <= w_presc_nxt;
      end
   end

   assign count   = w_count;
   assign state   = r_state;
   assign winner  = r_winner;
   assign timeout = r_timeout;
   assign tick    = r_tick;

endmodule

// File: doc/round_timer_controller.md
ROUND_TIMER_CONTROLLER -- requirements
Module: round_timer_controller

Interface
REQ-001 Parameter TICKS_PER_SEC, default 1000, clk cycles per one-second tick (1 kHz clk); legal range 2..65535.
REQ-002 Parameter ROUND_LIMIT, default 8'h30, packed-BCD round length in seconds; legal range 8'h01..8'h99, both digits 0..9.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 start  input  1  level; rising edge arms or clears a round.
REQ-006 red_button  input  1  level; red player press, rising edge significant.
REQ-007 blue_button  input  1  level; blue player press, rising edge significant.
REQ-008 count  output  8  elapsed seconds, packed BCD {tens, units}.
REQ-009 state  output  2  00 IDLE, 01 RUN, 10 DONE (11 unused).
REQ-010 winner  output  2  00 none, 01 red, 10 blue, 11 tie.
REQ-011 timeout  output  1  high in DONE when the round ended at ROUND_LIMIT.
REQ-012 tick  output  1  one-cycle pulse per elapsed second, RUN only.

Function
REQ-013 Inputs are synchronous to clk; the block detects each rising edge by comparing the input with its value registered on the previous cycle.
REQ-014 IDLE: count=8'h00, winner=00, timeout=0, prescaler=0; a start edge moves to RUN on the next edge; button edges are ignored.
REQ-015 RUN: prescaler counts 0..TICKS_PER_SEC-1 and wraps; at the terminal value, tick=1 for that cycle and count increments by 1 BCD.
REQ-016 BCD increment: units 9->0 with carry into tens, else units+1; no digit ever holds a value above 9.
REQ-017 A tick that brings count equal to ROUND_LIMIT moves to DONE with timeout=1 and winner=00; count shows ROUND_LIMIT.
REQ-018 A red edge alone in RUN moves to DONE with winner=01; a blue edge alone gives 10; both edges in the same cycle give 11.
REQ-019 Priority in RUN: a button edge beats a tick in the same cycle. tick is still asserted, but count is not incremented and timeout stays 0.
REQ-020 A start edge in RUN is ignored.
REQ-021 Latency: a button edge seen in cycle n gives state=DONE and a valid winner in cycle n+1.
REQ-022 DONE: count, winner and timeout hold; tick=0; prescaler holds; button edges are ignored.
REQ-023 A start edge in DONE moves to IDLE, clearing count, winner and timeout. A further start edge is needed to begin RUN.
REQ-024 A button held high across the IDLE->RUN transition does not end the round; only a fresh 0->1 transition counts.
REQ-025 All outputs are registered; no combinational path from input to output.

Reset
REQ-026 When reset_n=0 at a clk edge, the block goes to IDLE. count=8'h00, winner=00, timeout=0, tick=0, prescaler=0.
REQ-027 When reset_n=0 at a clk edge, edge-detect registers load the current levels of start, red_button and blue_button, so a level already high at reset release is not treated as an edge.
REQ-028 Reset mid-RUN or mid-DONE discards the round immediately; reset overrides every other event in the same cycle.

Structure
REQ-029 A shared package holds: the state encoding (IDLE/RUN/DONE), the winner codes (NONE/RED/BLUE/TIE), and the 4-bit BCD digit type.
REQ-030 One sub-module, bcd_pair_counter, holds the 2-digit BCD register with synchronous clear and enable, per REQ-016.
REQ-031 The FSM, prescaler and edge detectors live in round_timer_controller; target size is 120-400 RTL lines.

Verification (TICKS_PER_SEC=4, ROUND_LIMIT=8'h03 unless noted)
REQ-032 Reset, then start pulse, no buttons -> tick every 4 cycles; count 01,02,03; state=DONE, timeout=1, winner=00 on the third tick.
REQ-033 Red edge 2 cycles after count=8'h01 -> next cycle state=DONE, winner=01, count=8'h01; later ticks do not change count.
REQ-034 Red and blue rise in the same cycle -> winner=11. Blue edge coincident with a tick -> winner=10, count not incremented, timeout=0.
REQ-035 ROUND_LIMIT=8'h12: count steps 09->10 (units wrap, tens carry) and stops at 8'h12 with timeout=1.
REQ-036 red_button held high through the start edge -> round continues. In DONE, start edge -> IDLE with count=00. reset_n=0 mid-RUN -> IDLE, all outputs 0 on the next edge.
